codec_i2c_arbiter: RTL

CODEC_I2C_ARBITER -- requirements
Module: codec_i2c_arbiter

---
 rtl/codec_i2c_arbiter_pkg.sv | 26 ++
 rtl/codec_i2c_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/codec_i2c_arbiter_pkg.sv
// Shared types and engine command encodings for the codec I2C arbiter.
// Kept separate so the config sequencer and iic_com side can agree on Start_Sig values.
package codec_i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] IDLE_CMD = 2'b00;
  localparam logic [1:0] WR_CMD   = 2'b01;
  localparam logic [1:0] RD_CMD   = 2'b10;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } i2c_cmd_t;

  function automatic logic [1:0] cmd_of(input logic rw);
    return rw ? RD_CMD : WR_CMD;
  endfunction

endpackage

// File: rtl/codec_i2c_arbiter.sv
// Two-requester arbiter in front of the iic_com engine: grants one transfer at a
// time, holds the command until Done_Sig or timeout, then forces one idle cycle.
module codec_i2c_arbiter
  import codec_i2c_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter bit          RR_EN       = 1'b1
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic       Done_Sig,
  input  logic [7:0] RdData
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_q;
  logic             owner_q;
  logic             rr_next_q;
  logic             rw_q;
  logic [1:0]       start_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic             done0_q;
  logic             done1_q;
  logic             err0_q;
  logic             err1_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             owner_d;
  i2c_cmd_t         cmd_d;

  // NOTE: combinational blocks assign every output first so no latch is inferred.
  always_comb begin
    owner_d = 1'b0;
    if (req0 && req1) begin
      owner_d = RR_EN ? rr_next_q : 1'b0;
    end else begin
      owner_d = !req0;
    end
    cmd_d = owner_d ? '{rw: rw1, addr: addr1, wdata: wdata1}
                    : '{rw: rw0, addr: addr0, wdata: wdata0};
  end

  // NOTE: all state lives in this one clocked block and uses non-blocking assignments.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_next_q <= 1'b0;
      rw_q      <= 1'b0;
      start_q   <= IDLE_CMD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            state_q   <= ST_GRANT;
            owner_q   <= owner_d;
            rr_next_q <= !owner_d;
            rw_q      <= cmd_d.rw;
            addr_q    <= cmd_d.addr;
            wdata_q   <= cmd_d.wdata;
            busy_q    <= 1'b1;
          end
        end

        ST_GRANT: begin
          cnt_q   <= '0;
          start_q <= cmd_of(rw_q);
          state_q <= ST_BUSY;
        end

        ST_BUSY: begin
          // Done_Sig is tested first so it wins over a same-cycle timeout.
          if (Done_Sig) begin
            start_q <= IDLE_CMD;
            rdata_q <= RdData;
            done0_q <= !owner_q;
            done1_q <= owner_q;
            state_q <= ST_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            start_q <= IDLE_CMD;
            done0_q <= !owner_q;
            done1_q <= owner_q;
            err0_q  <= !owner_q;
            err1_q  <= owner_q;
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign Start_Sig = start_q;
  assign Addr_Sig  = addr_q;
  assign WrData    = wdata_q;

endmodule
